// File: rtl/axi_irq_ctrl.sv
// axi_irq_ctrl: AXI4-Lite interrupt controller for the PicoRV32 irq/eoi pins.
// Rising edges on i_irq_src latch into PENDING, ENABLE masks them, and one
// interrupt at a time (lowest index first) is driven on o_irq and retired by
// the CPU's eoi handshake.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   i_axi_aw*/w*/b*     AXI4-Lite write channel (single outstanding write)
//   i_axi_ar*/r*        AXI4-Lite read channel (single outstanding read)
//   i_irq_src           level interrupt sources, synchronous to clk
//   o_irq               one-hot interrupt to the CPU (at most one bit set)
//   i_eoi               end-of-interrupt from the CPU
//
// Register map (offset[3:2]): 0x00 PENDING (W1C), 0x04 ENABLE (RW),
// 0x08 STATUS ([31] active, [4:0] index), 0x0C SWTRIG (W1S to PENDING).
// Offsets >= 0x10 read 0, ignore writes and answer SLVERR.

// Single pending bit; set has priority over clear.
module irq_pend_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic pend
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pend <= 1'b0;
        else if (set) pend <= 1'b1;
        else if (clr) pend <= 1'b0;
    end
endmodule

module axi_irq_ctrl #(
    parameter int AXI_ADDR_BW_p = 12,
    parameter int IRQ_NBR_p     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
    input  logic                     i_axi_awvalid,
    output logic                     o_axi_awready,
    input  logic [31:0]              i_axi_wdata,
    input  logic [3:0]               i_axi_wstrb,
    input  logic                     i_axi_wvalid,
    output logic                     o_axi_wready,
    output logic [1:0]               o_axi_bresp,
    output logic                     o_axi_bvalid,
    input  logic                     i_axi_bready,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
    input  logic                     i_axi_arvalid,
    output logic                     o_axi_arready,
    output logic [31:0]              o_axi_rdata,
    output logic [1:0]               o_axi_rresp,
    output logic                     o_axi_rvalid,
    input  logic                     i_axi_rready,
    input  logic [IRQ_NBR_p-1:0]     i_irq_src,
    output logic [IRQ_NBR_p-1:0]     o_irq,
    input  logic [IRQ_NBR_p-1:0]     i_eoi
);
    localparam int IDX_W = 5;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;
    state_t state_q, state_d;

    logic [IRQ_NBR_p-1:0] src_q, pending, enable_q;
    logic [IRQ_NBR_p-1:0] irq_set, irq_clr, w1c_clr, sw_set, eoi_clr, req, k_oh;
    logic [IDX_W-1:0]     k_q, lo_idx;
    logic                 wr_acc, rd_acc, wr_map, rd_map;
    logic [1:0]           wr_off, rd_off;
    logic [31:0]          wmask, wbits, rd_word;
    logic                 unused_bits;

    // ---------------- write channel ----------------
    assign wr_acc        = i_axi_awvalid & i_axi_wvalid & ~o_axi_bvalid;
    assign o_axi_awready = wr_acc;
    assign o_axi_wready  = wr_acc;
    assign wr_off        = i_axi_awaddr[3:2];
    assign wr_map        = (i_axi_awaddr[AXI_ADDR_BW_p-1:4] == '0);

    always_comb begin
        wmask = '0;
        for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{i_axi_wstrb[b]}};
    end
    assign wbits = i_axi_wdata & wmask;

    always_comb begin
        w1c_clr = '0;
        sw_set  = '0;
        if (wr_acc && wr_map) begin
            case (wr_off)
                2'd0:    w1c_clr = wbits[IRQ_NBR_p-1:0];
                2'd3:    sw_set  = wbits[IRQ_NBR_p-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '0;
        end else if (wr_acc && wr_map && wr_off == 2'd1) begin
            enable_q <= (enable_q & ~wmask[IRQ_NBR_p-1:0]) | wbits[IRQ_NBR_p-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_axi_bvalid <= 1'b0;
            o_axi_bresp  <= RESP_OKAY;
        end else if (wr_acc) begin
            o_axi_bvalid <= 1'b1;
            o_axi_bresp  <= wr_map ? RESP_OKAY : RESP_SLVERR;
        end else if (i_axi_bready) begin
            o_axi_bvalid <= 1'b0;
        end
    end

    // ---------------- pending bits ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) src_q <= '0;
        else        src_q <= i_irq_src;
    end

    assign irq_set = (i_irq_src & ~src_q) | sw_set;
    assign irq_clr = w1c_clr | eoi_clr;

    for (genvar i = 0; i < IRQ_NBR_p; i++) begin : g_pend
        irq_pend_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .set  (irq_set[i]),
            .clr  (irq_clr[i]),
            .pend (pending[i])
        );
    end

    // ---------------- delivery FSM ----------------
    assign req = pending & enable_q;

    // Scan downward so the lowest requesting index is the last one written.
    always_comb begin
        lo_idx = '0;
        for (int i = IRQ_NBR_p - 1; i >= 0; i--) if (req[i]) lo_idx = IDX_W'(i);
    end

    always_comb begin
        k_oh = '0;
        for (int i = 0; i < IRQ_NBR_p; i++) k_oh[i] = (k_q == IDX_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && |req) k_q <= lo_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (|req) state_d = S_ASSERT;
            S_ASSERT: begin
                if (|(i_eoi & k_oh))                    state_d = S_SERVICE;
                // withdrawn by software (disabled or W1C'd) before the CPU took it
                else if (~|(enable_q & pending & k_oh)) state_d = S_IDLE;
            end
            S_SERVICE: if (~|(i_eoi & k_oh)) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_irq   = (state_q == S_ASSERT) ? k_oh : '0;
        eoi_clr = (state_q == S_ASSERT) ? (i_eoi & k_oh) : '0;
    end

    // ---------------- read channel ----------------
    assign rd_acc        = i_axi_arvalid & ~o_axi_rvalid;
    assign o_axi_arready = rd_acc;
    assign rd_off        = i_axi_araddr[3:2];
    assign rd_map        = (i_axi_araddr[AXI_ADDR_BW_p-1:4] == '0);

    always_comb begin
        rd_word = '0;
        if (rd_map) begin
            case (rd_off)
                2'd0: rd_word[IRQ_NBR_p-1:0] = pending;
                2'd1: rd_word[IRQ_NBR_p-1:0] = enable_q;
                2'd2: begin
                    rd_word[31]      = (state_q != S_IDLE);
                    rd_word[IDX_W-1:0] = (state_q != S_IDLE) ? k_q : '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_axi_rvalid <= 1'b0;
            o_axi_rdata  <= '0;
            o_axi_rresp  <= RESP_OKAY;
        end else if (rd_acc) begin
            o_axi_rvalid <= 1'b1;
            o_axi_rdata  <= rd_word;
            o_axi_rresp  <= rd_map ? RESP_OKAY : RESP_SLVERR;
        end else if (i_axi_rready) begin
            o_axi_rvalid <= 1'b0;
        end
    end

    // Address byte-offset bits and data bits above IRQ_NBR_p carry no state.
    assign unused_bits = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0], wbits, wmask};

endmodule

// File: tb/tb_axi_irq_ctrl.sv
// Scoreboard bench for axi_irq_ctrl: each AXI access pushes its expected
// response; a monitor pops and compares on every R/B handshake. Interrupt
// pin timing is checked inline against hand-derived cycle counts.
module tb_axi_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [7:0]  irq_src, irq, eoi;

    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_r[$];   // {rresp, rdata}
    logic [1:0]  exp_b[$];

    always #5 clk = ~clk;

    axi_irq_ctrl #(.AXI_ADDR_BW_p(12), .IRQ_NBR_p(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .o_axi_awready(awready),
        .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid),
        .o_axi_wready(wready), .o_axi_bresp(bresp), .o_axi_bvalid(bvalid),
        .i_axi_bready(bready), .i_axi_araddr(araddr), .i_axi_arvalid(arvalid),
        .o_axi_arready(arready), .o_axi_rdata(rdata), .o_axi_rresp(rresp),
        .o_axi_rvalid(rvalid), .i_axi_rready(rready),
        .i_irq_src(irq_src), .o_irq(irq), .i_eoi(eoi)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every completed R and B beat against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rvalid && rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
            else begin
                logic [33:0] e;
                e = exp_r.pop_front();
                chk("rdata", rdata, e[31:0]);
                chk("rresp", {30'd0, rresp}, {30'd0, e[33:32]});
            end
        end
        if (bvalid && bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                logic [1:0] eb;
                eb = exp_b.pop_front();
                chk("bresp", {30'd0, bresp}, {30'd0, eb});
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er,
                             input logic [7:0] src);
        int n;
        exp_b.push_back(er);
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        irq_src = src;   // lets a source edge land on the handshake cycle
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("aw_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; irq_src = 0;
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        exp_r.push_back({er, ed});
        @(posedge clk); #1;
        araddr = a; arvalid = 1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("ar_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 0;
        @(negedge clk);
        chk("rvalid_lat", rvalid, 1);
    endtask

    task automatic pulse_src(input logic [7:0] m);
        @(posedge clk); #1 irq_src = m;
        @(posedge clk); #1 irq_src = 0;
    endtask

    task automatic eoi_handshake(input logic [7:0] m);
        @(posedge clk); #1 eoi = m;
        @(posedge clk); #1 eoi = 0;
        @(posedge clk);
    endtask

    initial begin
        rst_n = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 1; araddr = 0; arvalid = 0; rready = 1; irq_src = 0; eoi = 0;

        // 1: reset state and zero reads
        repeat (2) @(negedge clk);
        chk("rst_irq", {24'd0, irq}, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_awready", awready, 0);
        @(posedge clk); #1 rst_n = 1;
        axi_read(12'h000, 32'h0, 2'b00);
        axi_read(12'h004, 32'h0, 2'b00);
        axi_read(12'h008, 32'h0, 2'b00);

        // 2: priority delivery and EOI sequencing
        axi_write(12'h004, 32'h18, 4'hF, 2'b00, 8'h00);
        pulse_src(8'h08);
        pulse_src(8'h10);
        @(negedge clk); chk("t2_irq3", {24'd0, irq}, 32'h08);
        axi_read(12'h000, 32'h18, 2'b00);
        axi_read(12'h008, 32'h8000_0003, 2'b00);
        @(posedge clk); #1 eoi = 8'h08;
        @(posedge clk);
        @(negedge clk); chk("t2_eoi_irq", {24'd0, irq}, 0);
        axi_read(12'h000, 32'h10, 2'b00);
        @(posedge clk); #1 eoi = 8'h00;
        @(posedge clk); @(negedge clk); chk("t2_gap", {24'd0, irq}, 0);
        @(posedge clk); @(negedge clk); chk("t2_irq4", {24'd0, irq}, 32'h10);
        eoi_handshake(8'h10);
        axi_read(12'h000, 32'h0, 2'b00);

        // 3: masked pending, delivered once enabled
        axi_write(12'h004, 32'h0, 4'hF, 2'b00, 8'h00);
        pulse_src(8'h20);
        repeat (2) @(negedge clk);
        chk("t3_masked", {24'd0, irq}, 0);
        axi_read(12'h000, 32'h20, 2'b00);
        axi_write(12'h004, 32'h20, 4'hF, 2'b00, 8'h00);
        @(negedge clk); chk("t3_pre", {24'd0, irq}, 0);
        @(negedge clk); chk("t3_irq5", {24'd0, irq}, 32'h20);
        eoi_handshake(8'h20);

        // 4: software W1C withdraws an asserted interrupt
        axi_write(12'h004, 32'h01, 4'hF, 2'b00, 8'h00);
        pulse_src(8'h01);
        @(posedge clk);
        @(negedge clk); chk("t4_irq0", {24'd0, irq}, 32'h01);
        axi_write(12'h000, 32'h01, 4'hF, 2'b00, 8'h00);
        @(negedge clk);
        @(negedge clk); chk("t4_withdrawn", {24'd0, irq}, 0);
        axi_read(12'h008, 32'h0, 2'b00);
        axi_read(12'h000, 32'h0, 2'b00);

        // 5: set beats clear, SWTRIG, strobe gating on W1C
        axi_write(12'h004, 32'h0, 4'hF, 2'b00, 8'h00);
        axi_write(12'h000, 32'h04, 4'hF, 2'b00, 8'h04);
        axi_read(12'h000, 32'h04, 2'b00);
        axi_write(12'h00C, 32'h80, 4'hF, 2'b00, 8'h00);
        axi_read(12'h000, 32'h84, 2'b00);
        axi_read(12'h00C, 32'h0, 2'b00);
        axi_write(12'h000, 32'h84, 4'h0, 2'b00, 8'h00);
        axi_read(12'h000, 32'h84, 2'b00);
        axi_write(12'h000, 32'h84, 4'h1, 2'b00, 8'h00);
        axi_read(12'h000, 32'h0, 2'b00);

        // 6: unmapped access and B backpressure
        axi_write(12'h00C, 32'h40, 4'hF, 2'b00, 8'h00);
        axi_write(12'h010, 32'h40, 4'hF, 2'b10, 8'h00);
        axi_read(12'h000, 32'h40, 2'b00);
        axi_read(12'h010, 32'h0, 2'b10);
        axi_write(12'h014, 32'hFF, 4'hF, 2'b10, 8'h00);
        axi_read(12'h004, 32'h0, 2'b00);
        exp_b.push_back(2'b10);
        @(posedge clk); #1;
        bready = 0;
        awaddr = 12'h010; wdata = 32'h40; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk); chk("t6_aw_first", awready, 1);
        @(posedge clk); #1;
        awaddr = 12'h00C; wdata = 32'h80;
        exp_b.push_back(2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_bvalid_hold", bvalid, 1);
            chk("t6_aw_blocked", awready, 0);
        end
        @(posedge clk); #1 bready = 1;
        @(negedge clk); chk("t6_aw_blocked_last", awready, 0);
        @(posedge clk);
        @(negedge clk); chk("t6_aw_second", awready, 1);
        @(posedge clk); #1 awvalid = 0; wvalid = 0;
        axi_read(12'h000, 32'hC0, 2'b00);
        axi_write(12'h000, 32'hC0, 4'hF, 2'b00, 8'h00);
        axi_read(12'h000, 32'h0, 2'b00);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drain", exp_r.size() + exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
